// File: rtl/hamming_minmax_engine.sv
// Hamming min/max engine: loads N operands from byte memory, sweeps every pair once, writes results back.
// Define HAM_PAIR_WRITEBACK_EN to also write the four pair indices after the two distances.

module hamming_minmax_engine #(
  parameter int DW          = 16,
  parameter int N           = 32,
  parameter int AW          = 8,
  parameter int BASE        = 0,
  parameter int RESULT_ADDR = 64,
  localparam int BPW = DW / 8,
  localparam int DSW = $clog2(DW + 1),
  localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_rd_en,
  input  logic [7:0]     mem_rd_data,
  output logic           mem_wr_en,
  output logic [7:0]     mem_wr_data,
  output logic [DSW-1:0] min_dist,
  output logic [DSW-1:0] max_dist,
  output logic [IW-1:0]  min_a,
  output logic [IW-1:0]  min_b,
  output logic [IW-1:0]  max_a,
  output logic [IW-1:0]  max_b
);

  localparam int NB  = N * BPW;
  localparam int CW  = $clog2(NB + 1);
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WCW = 3;
`ifdef HAM_PAIR_WRITEBACK_EN
  localparam int WN  = 6;
`else
  localparam int WN  = 2;
`endif

  localparam logic [CW-1:0]  NB_C       = CW'(NB);
  localparam logic [BCW-1:0] LAST_BYTE  = BCW'(BPW - 1);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(N - 1);
  localparam logic [IW-1:0]  LAST_J     = IW'(N - 2);
  localparam logic [WCW-1:0] LAST_WRITE = WCW'(WN - 1);
  localparam logic [DSW-1:0] DIST_INIT  = DSW'(DW);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPARE, S_WRITE, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  cap_idx_q, cap_idx_d;
  logic [BCW-1:0] cap_byte_q, cap_byte_d;
  logic [IW-1:0]  j_q, j_d, k_q, k_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [DSW-1:0] min_dist_q, min_dist_d, max_dist_q, max_dist_d;
  logic [IW-1:0]  min_a_q, min_a_d, min_b_q, min_b_d;
  logic [IW-1:0]  max_a_q, max_a_d, max_b_q, max_b_d;
  logic [DW-1:0]  op_q [N];
  logic           op_we;
  logic [DSW-1:0] pair_dist;
  logic           last_pair;

  function automatic logic [DSW-1:0] popcount(input logic [DW-1:0] v);
    logic [DSW-1:0] c;
    c = '0;
    for (int i = 0; i < DW; i++) c = c + DSW'(v[i]);
    return c;
  endfunction

  assign pair_dist = popcount(op_q[j_q] ^ op_q[k_q]);
  assign last_pair = (j_q == LAST_J) && (k_q == LAST_IDX);

  always_comb begin
    // NOTE: every _d starts from its current value, so no branch below can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_idx_d  = cap_idx_q;
    cap_byte_d = cap_byte_q;
    j_d        = j_q;
    k_d        = k_q;
    wr_cnt_d   = wr_cnt_q;
    min_dist_d = min_dist_q;
    max_dist_d = max_dist_q;
    min_a_d    = min_a_q;
    min_b_d    = min_b_q;
    max_a_d    = max_a_q;
    max_b_d    = max_b_q;
    op_we      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          cnt_d      = '0;
          cap_idx_d  = '0;
          cap_byte_d = '0;
          j_d        = '0;
          k_d        = IW'(1);
          wr_cnt_d   = '0;
          min_dist_d = DIST_INIT;
          max_dist_d = '0;
          min_a_d    = '0;
          min_b_d    = '0;
          max_a_d    = '0;
          max_b_d    = '0;
        end
      end
      S_LOAD: begin
        cnt_d = cnt_q + CW'(1);
        // Read data trails the address by one cycle, so capture lags the issue counter by one.
        if (cnt_q != '0) begin
          op_we = 1'b1;
          if (cap_byte_q == LAST_BYTE) begin
            cap_byte_d = '0;
            cap_idx_d  = cap_idx_q + IW'(1);
          end else begin
            cap_byte_d = cap_byte_q + BCW'(1);
          end
        end
        if (cnt_q == NB_C) state_d = (N < 2) ? S_WRITE : S_COMPARE;
      end
      S_COMPARE: begin
        if (pair_dist < min_dist_q) begin
          min_dist_d = pair_dist;
          min_a_d    = j_q;
          min_b_d    = k_q;
        end
        if (pair_dist > max_dist_q) begin
          max_dist_d = pair_dist;
          max_a_d    = j_q;
          max_b_d    = k_q;
        end
        if (last_pair) begin
          state_d = S_WRITE;
        end else if (k_q == LAST_IDX) begin
          j_d = j_q + IW'(1);
          k_d = j_q + IW'(2);
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_WRITE: begin
        wr_cnt_d = wr_cnt_q + WCW'(1);
        if (wr_cnt_q == LAST_WRITE) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cap_idx_q  <= '0;
      cap_byte_q <= '0;
      j_q        <= '0;
      k_q        <= '0;
      wr_cnt_q   <= '0;
      min_dist_q <= DIST_INIT;
      max_dist_q <= '0;
      min_a_q    <= '0;
      min_b_q    <= '0;
      max_a_q    <= '0;
      max_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_idx_q  <= cap_idx_d;
      cap_byte_q <= cap_byte_d;
      j_q        <= j_d;
      k_q        <= k_d;
      wr_cnt_q   <= wr_cnt_d;
      min_dist_q <= min_dist_d;
      max_dist_q <= max_dist_d;
      min_a_q    <= min_a_d;
      min_b_q    <= min_b_d;
      max_a_q    <= max_a_d;
      max_b_q    <= max_b_d;
    end
  end

  // NOTE: the operand cache is not reset; LOAD rewrites every entry before COMPARE reads any of them.
  always_ff @(posedge clk) begin
    if (op_we && !reset) op_q[cap_idx_q] <= (op_q[cap_idx_q] << 8) | DW'(mem_rd_data);
  end

  always_comb begin
    busy        = (state_q == S_LOAD) || (state_q == S_COMPARE) || (state_q == S_WRITE);
    done        = (state_q == S_DONE);
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state_q)
      S_LOAD: begin
        if (cnt_q < NB_C) begin
          mem_rd_en = 1'b1;
          mem_addr  = AW'(BASE) + AW'(cnt_q);
        end
      end
      S_WRITE: begin
        // Synchronous reset must also cancel the write that would land on the same edge.
        mem_wr_en = !reset;
        mem_addr  = AW'(RESULT_ADDR) + AW'(wr_cnt_q);
        case (wr_cnt_q)
          3'd0:    mem_wr_data = 8'(min_dist_q);
          3'd1:    mem_wr_data = 8'(max_dist_q);
`ifdef HAM_PAIR_WRITEBACK_EN
          3'd2:    mem_wr_data = 8'(min_a_q);
          3'd3:    mem_wr_data = 8'(min_b_q);
          3'd4:    mem_wr_data = 8'(max_a_q);
          3'd5:    mem_wr_data = 8'(max_b_q);
`endif
          default: mem_wr_data = '0;
        endcase
      end
      default: ;
    endcase
  end

  assign min_dist = min_dist_q;
  assign max_dist = max_dist_q;
  assign min_a    = min_a_q;
  assign min_b    = min_b_q;
  assign max_a    = max_a_q;
  assign max_b    = max_b_q;

endmodule
